// File: rtl/cpu_memory_unit.sv
// Unified instruction/data memory for the single-cycle RISC-V core: shared word array,
// sized loads/stores with handshake pulses, power-up clear and a registered LCD mirror window.
module cpu_memory_unit #(
  parameter int DEPTH_WORDS = 32,
  parameter int READ_LAT    = 1,
  parameter int LCD_BASE    = 16,
  parameter int LCD_WORDS   = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [31:0]               i_addr,
  input  logic                      i_inst_req,
  output logic [31:0]               o_mem_inst,
  output logic                      o_mem_inst_enb,
  input  logic                      i_mem_req,
  input  logic                      i_mem_write_enable,
  input  logic [1:0]                i_mem_size,
  input  logic                      i_mem_unsigned,
  input  logic [15:0]               i_mem_addr,
  input  logic [31:0]               i_mem_store,
  output logic [31:0]               o_mem_load,
  output logic                      o_read_enable,
  output logic                      o_mem_ack,
  output logic                      o_mem_fault,
  output logic                      o_busy,
  output logic [32*LCD_WORDS-1:0]   o_lcd_buffer
);

  // state     | meaning
  // INIT      | clearing one word per cycle after reset
  // IDLE      | arbitrating MEM_REQ over INST_REQ
  // WAIT      | read latency down-counter running
  // DONE      | load/fetch result valid, pulse issued
  // STORE_ACK | store committed, MEM_ACK pulse
  // FAULT     | access rejected, MEM_FAULT pulse
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WAIT, S_DONE, S_STORE_ACK, S_FAULT
  } state_t;

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t r_state;
  state_t w_next;

  logic [31:0]            r_mem [DEPTH_WORDS];
  logic [AW-1:0]          r_clr;
  logic [AW-1:0]          r_idx;
  logic [1:0]             r_off;
  logic [1:0]             r_size;
  logic                   r_uns;
  logic                   r_fetch;
  logic [2:0]             r_cnt;
  logic [31:0]            r_mem_load;
  logic [31:0]            r_mem_inst;
  logic [32*LCD_WORDS-1:0] r_lcd;

  logic [2:0]    w_cnt_next;
  logic          w_accept;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_idx;
  logic [31:0]   w_wr_data;
  logic [3:0]    w_be;
  logic [AW-1:0] w_cur_idx;
  logic [1:0]    w_cur_off;
  logic [1:0]    w_cur_size;
  logic          w_cur_uns;
  logic          w_cur_fetch;
  logic          w_d_fault;
  logic          w_i_fault;
  logic [31:0]   w_rd_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;
  logic          w_load_out;
  logic          w_inst_out;

  // Any address bit above the array range set means the access cannot be served.
  assign w_d_fault = (i_mem_size == 2'b11)
                   | ((i_mem_size == 2'b01) & i_mem_addr[0])
                   | ((i_mem_size == 2'b10) & (i_mem_addr[1:0] != 2'b00))
                   | ((i_mem_addr >> (AW + 2)) != 16'd0);
  assign w_i_fault = (i_addr[1:0] != 2'b00) | ((i_addr >> (AW + 2)) != 32'd0);

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_accept    = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_clr;
    w_wr_data   = 32'd0;
    w_be        = 4'h0;
    w_cur_idx   = r_idx;
    w_cur_off   = r_off;
    w_cur_size  = r_size;
    w_cur_uns   = r_uns;
    w_cur_fetch = r_fetch;
    case (r_state)
      S_INIT: begin
        w_wr_en = 1'b1;
        w_be    = 4'hF;
        if (r_clr == AW'(DEPTH_WORDS - 1)) w_next = S_IDLE;
      end
      S_IDLE: begin
        if (i_mem_req || i_inst_req) begin
          w_accept = 1'b1;
          if (i_mem_req) begin
            w_cur_idx   = i_mem_addr[AW+1:2];
            w_cur_off   = i_mem_addr[1:0];
            w_cur_size  = i_mem_size;
            w_cur_uns   = i_mem_unsigned;
            w_cur_fetch = 1'b0;
          end else begin
            w_cur_idx   = i_addr[AW+1:2];
            w_cur_off   = i_addr[1:0];
            w_cur_size  = 2'b10;
            w_cur_uns   = 1'b0;
            w_cur_fetch = 1'b1;
          end
          if (i_mem_req ? w_d_fault : w_i_fault) begin
            w_next = S_FAULT;
          end else if (i_mem_req && i_mem_write_enable) begin
            w_wr_en  = 1'b1;
            w_wr_idx = w_cur_idx;
            w_next   = S_STORE_ACK;
            case (i_mem_size)
              2'b00: begin
                w_wr_data = {4{i_mem_store[7:0]}};
                w_be      = 4'b0001 << i_mem_addr[1:0];
              end
              2'b01: begin
                w_wr_data = {2{i_mem_store[15:0]}};
                w_be      = i_mem_addr[1] ? 4'b1100 : 4'b0011;
              end
              default: begin
                w_wr_data = i_mem_store;
                w_be      = 4'hF;
              end
            endcase
          end else if (READ_LAT == 1) begin
            w_next = S_DONE;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = 3'(READ_LAT - 1);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd1) w_next = S_DONE;
        else               w_cnt_next = r_cnt - 3'd1;
      end
      S_DONE:      w_next = S_IDLE;
      S_STORE_ACK: w_next = S_IDLE;
      S_FAULT:     w_next = S_IDLE;
      default:     w_next = S_INIT;
    endcase
    if (i_rst) w_wr_en = 1'b0;
  end

  assign w_rd_word  = r_mem[w_cur_idx];
  assign w_byte     = w_rd_word[8*w_cur_off +: 8];
  assign w_half     = w_cur_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];
  assign w_load_out = (w_next == S_DONE) && !w_cur_fetch;
  assign w_inst_out = (w_next == S_DONE) && w_cur_fetch;

  always_comb begin
    case (w_cur_size)
      2'b00:   w_ext = w_cur_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ext = w_cur_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = w_rd_word;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_INIT;
      r_clr      <= '0;
      r_idx      <= '0;
      r_off      <= 2'b00;
      r_size     <= 2'b00;
      r_uns      <= 1'b0;
      r_fetch    <= 1'b0;
      r_cnt      <= 3'd0;
      r_mem_load <= 32'd0;
      r_mem_inst <= 32'd0;
      r_lcd      <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_INIT) r_clr <= r_clr + 1'b1;
      if (w_accept) begin
        r_idx   <= w_cur_idx;
        r_off   <= w_cur_off;
        r_size  <= w_cur_size;
        r_uns   <= w_cur_uns;
        r_fetch <= w_cur_fetch;
      end
      if (w_load_out) r_mem_load <= w_ext;
      if (w_inst_out) r_mem_inst <= w_rd_word;
      if (w_wr_en) begin
        for (int k = 0; k < LCD_WORDS; k++) begin
          if (32'(w_wr_idx) == 32'(LCD_BASE + k)) begin
            for (int b = 0; b < 4; b++) begin
              if (w_be[b]) r_lcd[32*(LCD_WORDS-1-k) + 8*b +: 8] <= w_wr_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  assign o_busy         = !i_rst && (r_state != S_IDLE);
  assign o_read_enable  = !i_rst && (r_state == S_DONE) && !r_fetch;
  assign o_mem_inst_enb = !i_rst && (r_state == S_DONE) && r_fetch;
  assign o_mem_ack      = !i_rst && (r_state == S_STORE_ACK);
  assign o_mem_fault    = !i_rst && (r_state == S_FAULT);
  assign o_mem_load     = i_rst ? 32'd0 : r_mem_load;
  assign o_mem_inst     = i_rst ? 32'd0 : r_mem_inst;
  assign o_lcd_buffer   = i_rst ? '0 : r_lcd;

endmodule

// File: doc/cpu_memory_unit.md
Name: cpu_memory_unit

Overview:
Synthesizable unified instruction/data memory for the single-cycle RISC-V core. It replaces the behavioural memory array and LCD mirror currently kept in the bench. Instruction fetch and data load/store share one single-ported, byte-addressed word array. Loads and stores support byte, half and word sizes with sign or zero extension, and every completion is signalled by a handshake pulse. A parametrised window of memory is mirrored onto a flat LCD buffer output.

Parameters:
DEPTH_WORDS, 32, number of 32-bit words; power of two, 4..4096
READ_LAT, 1, cycles from request acceptance to data valid for fetch and load; 1..4
LCD_BASE, 16, word index of the first LCD-mirrored word; LCD_BASE+LCD_WORDS <= DEPTH_WORDS
LCD_WORDS, 8, number of mirrored words; LCD_BUFFER width = 32*LCD_WORDS

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
ADDR  in  32  instruction byte address from the PC
INST_REQ  in  1  fetch request, level; sampled in IDLE
MEM_INST  out  32  fetched instruction word
MEM_INST_ENB  out  1  one-cycle pulse: MEM_INST valid
MEM_REQ  in  1  data request, level; sampled in IDLE
MEM_WRITE_ENABLE  in  1  1 = store, 0 = load; qualified by MEM_REQ
MEM_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal
MEM_UNSIGNED  in  1  load zero-extend (LBU/LHU) when 1, sign-extend when 0
MEM_ADDR  in  16  data byte address
MEM_STORE  in  32  store data; low bits are used for sub-word stores
MEM_LOAD  out  32  extended load result
READ_ENABLE  out  1  one-cycle pulse: MEM_LOAD valid
MEM_ACK  out  1  one-cycle pulse: store committed
MEM_FAULT  out  1  one-cycle pulse: access rejected
BUSY  out  1  high in every state except IDLE
LCD_BUFFER  out  32*LCD_WORDS  word LCD_BASE in the MSBs, down to word LCD_BASE+LCD_WORDS-1 in the LSBs

Behaviour:
- Addressing:
  - Byte addressed, word index = addr[log2(DEPTH)+1:2], little-endian within the word.
  - Address bits above the array range must be zero; otherwise the access faults.
- Reset: while RST=1 all outputs are 0 and the state is INIT with the clear counter at 0. RST asserted in any state, mid-access included, aborts the access; no pulse is issued and no partial write occurs.
- INIT: writes 0 to one word per cycle, index 0..DEPTH-1, then moves to IDLE. This takes DEPTH_WORDS cycles. Requests arriving in INIT are ignored, not queued. BUSY=1.
- IDLE arbitration: MEM_REQ has priority over INST_REQ. A fetch held off by a data access is served in the next IDLE cycle if INST_REQ is still high.
- Fault check at acceptance. An access faults on:
  - MEM_SIZE=11;
  - a half access with addr[0]=1;
  - a word access with addr[1:0]!=00;
  - an out-of-range address;
  - a fetch with ADDR[1:0]!=00.

  A faulting access pulses MEM_FAULT on the next cycle, causes no array write, leaves MEM_LOAD/MEM_INST unchanged and returns to IDLE.
- Store: accepted in IDLE and written at that edge. Byte enables are derived from size and addr[1:0]; unselected bytes are preserved. MEM_ACK pulses the following cycle (state STORE_ACK), then IDLE. Store-to-load latency is therefore 2 cycles minimum.
- Load and fetch: the state goes to WAIT and a counter runs READ_LAT-1 cycles; in DONE the output register is loaded and READ_ENABLE or MEM_INST_ENB pulses. Latency from acceptance edge to pulse = READ_LAT cycles. Address and control are captured at acceptance, so input changes during WAIT have no effect.
- Load extension:
  - byte = word[8*a+7:8*a] extended from bit 7;
  - half = word[16*a1+15:16*a1] extended from bit 15;
  - word = unchanged.
- Outputs are held between accesses. Pulses are exactly one cycle wide and never coincide.
- LCD_BUFFER is registered. It updates on the cycle after any write into the window (including INIT clears) and reads 0 after reset.
- Back-to-back: the next request can be accepted in the first IDLE cycle after a pulse. Throughput is one access per READ_LAT+1 cycles.

Test Plan:
1. RST=1 for 2 cycles, then 0 -> BUSY=1 for exactly 32 cycles; every word reads 0; LCD_BUFFER=0.
2. Store word 0x20202031 at MEM_ADDR=0x40, then LB/LBU at 0x43 -> MEM_ACK one cycle after acceptance; LB loads 0x00000020; word load at 0x40 returns 0x20202031; LCD_BUFFER[255:224]=0x20202031.
3. Store byte 0xFF at 0x7D over word 0x11223344 at 0x7C -> word reads 0x1122FF44; LB 0x7D gives 0xFFFFFFFF; LBU 0x7D gives 0x000000FF; LH 0x7C gives 0xFFFFFF44.
4. MEM_REQ (load 0x04) and INST_REQ (ADDR=0x08) raised in the same IDLE cycle, READ_LAT=3 -> READ_ENABLE at +3; the fetch is accepted in the following IDLE and MEM_INST_ENB pulses 3 cycles after that.
5. Half load at 0x03, word store at 0x42, MEM_SIZE=11, MEM_ADDR=0x0100 -> MEM_FAULT each time; array and MEM_LOAD unchanged.
6. RST asserted during WAIT of a load with READ_LAT=4 -> no READ_ENABLE pulse; INIT restarts and clears the array.
